irq_priority_sched: RTL and testbench

IRQ_PRIORITY_SCHED -- requirements
Module: irq_priority_sched

---
 rtl/irq_sched_pkg.sv | 24 ++
 rtl/wb_if.sv | 15 +
 rtl/irq_prio_tree.sv | 30 +++
 rtl/irq_priority_sched.sv | 161 ++++++++++++++++
 tb/tb_irq_priority_sched.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_sched_pkg.sv
// Register map, FSM state type and shared sizes for the IRQ priority scheduler.
// IRQ_SCHED_NEST_EN selects a 4-deep in-service stack (nesting); otherwise depth 1.
package irq_sched_pkg;

    localparam logic [5:0] RegEnable   = 6'd0;
    localparam logic [5:0] RegPending  = 6'd1;
    localparam logic [5:0] RegClaim    = 6'd2;
    localparam logic [5:0] RegEoi      = 6'd3;
    localparam logic [5:0] RegCurpri   = 6'd4;
    localparam logic [5:0] RegDepth    = 6'd5;
    localparam logic [5:0] RegPrioBase = 6'd16;

    localparam int unsigned PriWDefault = 4;
    typedef logic [PriWDefault-1:0] pri_t;

    typedef enum logic [1:0] {StIdle, StReq, StSvc, StFull} irq_state_e;

`ifdef IRQ_SCHED_NEST_EN
    localparam int unsigned StackDepth = 4;
`else
    localparam int unsigned StackDepth = 1;
`endif

endpackage

// File: rtl/wb_if.sv
// 32-bit Wishbone classic register-port bundle.
interface wb_if;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;

    modport master (output adr, sel, we, dat_w, cyc, stb, input dat_r, ack, err);
    modport slave  (input adr, sel, we, dat_w, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/irq_prio_tree.sv
// Combinational best-source resolver: highest priority among pending, ties to lowest index.
module irq_prio_tree #(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned PRI_W   = 4
) (
    input  logic [NUM_SRC-1:0] pending_i,
    input  logic [PRI_W-1:0]   prio_i [NUM_SRC],
    output logic               valid_o,
    output logic [3:0]         id_o,
    output logic [PRI_W-1:0]   pri_o
);
    logic [3:0]       best_id;
    logic [PRI_W-1:0] best_pri;

    always_comb begin
        best_id  = '0;
        best_pri = '0;
        // Strict compare keeps the lowest index on ties and never picks priority 0.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending_i[i] && (prio_i[i] > best_pri)) begin
                best_pri = prio_i[i];
                best_id  = 4'(i);
            end
        end
    end

    assign valid_o = (best_pri != '0);
    assign id_o    = best_id;
    assign pri_o   = best_pri;
endmodule

// File: rtl/irq_priority_sched.sv
// Interrupt priority scheduler: Wishbone registers, registered arbitration, in-service stack.
// Defining IRQ_SCHED_NEST_EN enables 4-level preemptive nesting.
module irq_priority_sched
    import irq_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned PRI_W   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    wb_if.slave                slave,
    input  logic [NUM_SRC-1:0] i_interrupts,
    output logic               o_irq,
    output logic [3:0]         o_irq_id
);
    localparam logic [2:0] DepthFull = 3'(StackDepth);

    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [PRI_W-1:0]   prio_q  [NUM_SRC];
    logic [PRI_W-1:0]   prio_d  [NUM_SRC];
    logic [PRI_W-1:0]   stack_q [StackDepth];
    logic [PRI_W-1:0]   stack_d [StackDepth];
    logic [2:0]         depth_q, depth_d;
    logic               best_valid_q;
    logic [3:0]         best_id_q;
    logic [PRI_W-1:0]   best_pri_q;
    logic               tree_valid;
    logic [3:0]         tree_id;
    logic [PRI_W-1:0]   tree_pri;
    irq_state_e         state_q, state_d;
    logic [3:0]         irq_id_q, irq_id_d;
    logic               rd_ack_q;
    logic [31:0]        dat_r_q, dat_r_d;
    logic [NUM_SRC-1:0] pending;
    logic [PRI_W-1:0]   curpri;
    logic               stack_full, eligible;
    logic [5:0]         reg_off;
    logic               wr_en, rd_en;
    logic               unused_bus;

    assign reg_off    = slave.adr[7:2];
    assign pending    = i_interrupts & enable_q;
    assign wr_en      = slave.cyc & slave.stb & slave.we;
    // The cycle carrying a read ACK must not be taken as a new read.
    assign rd_en      = slave.cyc & slave.stb & ~slave.we & ~rd_ack_q;
    assign unused_bus = ^{slave.adr[31:8], slave.adr[1:0], slave.dat_w, slave.sel};

    irq_prio_tree #(
        .NUM_SRC(NUM_SRC),
        .PRI_W  (PRI_W)
    ) u_prio_tree (
        .pending_i(pending),
        .prio_i   (prio_q),
        .valid_o  (tree_valid),
        .id_o     (tree_id),
        .pri_o    (tree_pri)
    );

    always_comb begin
        curpri = '0;
        for (int s = 0; s < StackDepth; s++) begin
            if (depth_q == 3'(s + 1)) curpri = stack_q[s];
        end
    end

    assign stack_full = (depth_q == DepthFull);
    assign eligible   = best_valid_q && (best_pri_q > curpri) && !stack_full;

    always_comb begin
        enable_d = enable_q;
        prio_d   = prio_q;
        stack_d  = stack_q;
        depth_d  = depth_q;
        dat_r_d  = '0;
        if (wr_en) begin
            if (reg_off == RegEnable) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (slave.sel[i / 8]) enable_d[i] = slave.dat_w[i];
                end
            end else if (reg_off == RegEoi) begin
                if (depth_q != 3'd0) depth_d = depth_q - 3'd1;
            end else begin
                for (int n = 0; n < NUM_SRC; n++) begin
                    if (reg_off == RegPrioBase + 6'(n) && slave.sel[0]) begin
                        prio_d[n] = slave.dat_w[PRI_W-1:0];
                    end
                end
            end
        end
        if (rd_en) begin
            case (reg_off)
                RegEnable:  dat_r_d = 32'(enable_q);
                RegPending: dat_r_d = 32'(pending);
                RegClaim: begin
                    if (eligible) begin
                        dat_r_d = {1'b1, 27'd0, best_id_q};
                        for (int s = 0; s < StackDepth; s++) begin
                            if (depth_q == 3'(s)) stack_d[s] = best_pri_q;
                        end
                        depth_d = depth_q + 3'd1;
                    end
                end
                RegCurpri:  dat_r_d = 32'(curpri);
                RegDepth:   dat_r_d = 32'(depth_q);
                default: begin
                    for (int n = 0; n < NUM_SRC; n++) begin
                        if (reg_off == RegPrioBase + 6'(n)) dat_r_d = 32'(prio_q[n]);
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_d  = StIdle;
        irq_id_d = '0;
        if (eligible) begin
            state_d  = StReq;
            irq_id_d = best_id_q;
        end else if (stack_full) begin
            state_d = StFull;
        end else if (depth_q != 3'd0) begin
            state_d = StSvc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            enable_q     <= '0;
            prio_q       <= '{default: '0};
            stack_q      <= '{default: '0};
            depth_q      <= '0;
            best_valid_q <= 1'b0;
            best_id_q    <= '0;
            best_pri_q   <= '0;
            state_q      <= StIdle;
            irq_id_q     <= '0;
            rd_ack_q     <= 1'b0;
            dat_r_q      <= '0;
        end else begin
            enable_q     <= enable_d;
            prio_q       <= prio_d;
            stack_q      <= stack_d;
            depth_q      <= depth_d;
            best_valid_q <= tree_valid;
            best_id_q    <= tree_id;
            best_pri_q   <= tree_pri;
            state_q      <= state_d;
            irq_id_q     <= irq_id_d;
            rd_ack_q     <= rd_en;
            dat_r_q      <= dat_r_d;
        end
    end

    // Write ACK is combinational, so it is gated to stay low while reset is held.
    assign slave.ack   = rd_ack_q | (wr_en & i_rst_n);
    assign slave.dat_r = dat_r_q;
    assign slave.err   = 1'b0;
    assign o_irq       = (state_q == StReq);
    assign o_irq_id    = irq_id_q;
endmodule

// File: tb/tb_irq_priority_sched.sv
// Self-checking bench for irq_priority_sched: directed scenarios plus randomized traffic
// checked every cycle against a queue-based model of the scheduler.
module tb_irq_priority_sched;
    import irq_sched_pkg::*;

    localparam int NSRC = 16;
    localparam int PW   = 4;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [NSRC-1:0] ints  = '0;
    logic            o_irq;
    logic [3:0]      o_irq_id;

    wb_if wb ();

    irq_priority_sched #(
        .NUM_SRC(NSRC),
        .PRI_W  (PW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .slave       (wb),
        .i_interrupts(ints),
        .o_irq       (o_irq),
        .o_irq_id    (o_irq_id)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_prio [NSRC];
    logic [NSRC-1:0] m_en = '0;
    int              m_stk[$];
    bit              m_bv = 0;
    int              m_bid = 0;
    int              m_bpri = 0;
    bit              m_irq = 0;
    int              m_id = 0;
    bit              m_rd_ack = 0;
    logic [31:0]     m_dat = '0;

    always @(posedge clk or negedge rst_n) begin
        int          cur, maxp, first;
        bit          elig, rd_fire;
        int          off;
        logic [31:0] rd;
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) m_prio[i] = 0;
            m_en = '0;
            m_stk.delete();
            m_bv = 0; m_bid = 0; m_bpri = 0;
            m_irq = 0; m_id = 0; m_rd_ack = 0; m_dat = '0;
        end else begin
            cur  = (m_stk.size() > 0) ? m_stk[m_stk.size() - 1] : 0;
            elig = m_bv && (m_bpri > cur) && (m_stk.size() < int'(StackDepth));
            off  = int'(wb.adr[7:2]);
            rd_fire = wb.cyc && wb.stb && !wb.we && !m_rd_ack;
            rd = '0;
            if (rd_fire) begin
                if (off == 0) rd = 32'(m_en);
                else if (off == 1) rd = 32'(ints & m_en);
                else if (off == 2) begin
                    if (elig) begin
                        rd = 32'h8000_0000 | 32'(m_bid);
                        m_stk.push_back(m_bpri);
                    end
                end
                else if (off == 4) rd = 32'(cur);
                else if (off == 5) rd = 32'(m_stk.size());
                else if (off >= 16 && off < 16 + NSRC) rd = 32'(m_prio[off - 16]);
            end
            // Highest priority among pending sources, then the lowest index holding it.
            maxp = 0;
            for (int i = 0; i < NSRC; i++)
                if (ints[i] && m_en[i] && m_prio[i] > maxp) maxp = m_prio[i];
            first = 0;
            for (int i = NSRC - 1; i >= 0; i--)
                if (ints[i] && m_en[i] && m_prio[i] == maxp) first = i;
            if (wb.cyc && wb.stb && wb.we) begin
                if (off == 0) m_en = wb.dat_w[NSRC-1:0];
                else if (off == 3) begin
                    if (m_stk.size() > 0) m_stk.delete(m_stk.size() - 1);
                end
                else if (off >= 16 && off < 16 + NSRC) m_prio[off - 16] = int'(wb.dat_w[PW-1:0]);
            end
            m_irq    = elig;
            m_id     = elig ? m_bid : 0;
            m_rd_ack = rd_fire;
            m_dat    = rd;
            m_bv     = (maxp > 0);
            m_bid    = first;
            m_bpri   = maxp;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("o_irq", 32'(o_irq), 32'(m_irq));
            chk("o_irq_id", 32'(o_irq_id), 32'(m_id));
            chk("ack", 32'(wb.ack), 32'(m_rd_ack || (wb.cyc && wb.stb && wb.we)));
            chk("err", 32'(wb.err), 32'd0);
            if (m_rd_ack) chk("dat_r", wb.dat_r, m_dat);
        end
    end

    // ---------------- bus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_write(input logic [5:0] off, input logic [31:0] data);
        wb.adr = {24'd0, off, 2'b00}; wb.dat_w = data; wb.sel = 4'hF;
        wb.we = 1'b1; wb.cyc = 1'b1; wb.stb = 1'b1;
        #1 chk("wr_ack_same_cycle", 32'(wb.ack), 32'd1);
        @(posedge clk);
        #1;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    endtask

    task automatic wb_read(input logic [5:0] off, output logic [31:0] data);
        wb.adr = {24'd0, off, 2'b00}; wb.sel = 4'hF;
        wb.we = 1'b0; wb.cyc = 1'b1; wb.stb = 1'b1;
        #1 chk("rd_ack_not_early", 32'(wb.ack), 32'd0);
        @(posedge clk);
        #1;
        chk("rd_ack_one_cycle", 32'(wb.ack), 32'd1);
        data = wb.dat_r;
        wb.cyc = 1'b0; wb.stb = 1'b0;
        idle(1);
    endtask

    logic [5:0] offs [12] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8,
                              6'd16, 6'd20, 6'd31, 6'd40};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        wb.adr = '0; wb.sel = '0; wb.we = 1'b0; wb.dat_w = '0; wb.cyc = 1'b0; wb.stb = 1'b0;
        #1;
        chk("rst_irq", 32'(o_irq), 32'd0);
        chk("rst_irq_id", 32'(o_irq_id), 32'd0);
        chk("rst_ack", 32'(wb.ack), 32'd0);
        chk("rst_dat_r", wb.dat_r, 32'd0);
        idle(3);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Single source: request latency, claim, CURPRI, re-arbitration after EOI.
        wb_write(6'd19, 32'd2);
        wb_write(6'd0, 32'h0008);
        ints[3] = 1'b1;
        idle(1);
        chk("irq_after_1", 32'(o_irq), 32'd0);
        idle(1);
        chk("irq_after_2", 32'(o_irq), 32'd1);
        chk("irq_id_3", 32'(o_irq_id), 32'd3);
        wb_read(6'd2, d);
        chk("claim_src3", d, 32'h8000_0003);
        wb_read(6'd4, d);
        chk("curpri_2", d, 32'd2);
        chk("irq_dropped", 32'(o_irq), 32'd0);
        wb_read(6'd5, d);
        chk("depth_1", d, 32'd1);
        wb_write(6'd3, 32'd0);
        idle(1);
        chk("rearb_after_eoi", 32'(o_irq), 32'd1);
        ints[3] = 1'b0;
        idle(3);
        chk("irq_low_released", 32'(o_irq), 32'd0);

        // Equal priorities resolve to the lowest index.
        wb_write(6'd17, 32'd5);
        wb_write(6'd23, 32'd5);
        wb_write(6'd0, 32'h008A);
        ints[1] = 1'b1; ints[7] = 1'b1;
        idle(2);
        chk("tie_irq", 32'(o_irq), 32'd1);
        chk("tie_id", 32'(o_irq_id), 32'd1);
        wb_read(6'd2, d);
        chk("claim_tie", d, 32'h8000_0001);
        wb_write(6'd3, 32'd0);
        ints[1] = 1'b0; ints[7] = 1'b0;
        idle(3);

        // Higher-priority source arrives while src 3 is in service.
        ints[3] = 1'b1;
        idle(2);
        wb_read(6'd2, d);
        chk("claim_svc", d, 32'h8000_0003);
        wb_write(6'd25, 32'd6);
        wb_write(6'd0, 32'h020A);
        ints[9] = 1'b1;
        idle(3);
`ifdef IRQ_SCHED_NEST_EN
        chk("preempt_irq", 32'(o_irq), 32'd1);
        chk("preempt_id", 32'(o_irq_id), 32'd9);
        wb_read(6'd2, d);
        chk("claim_nested", d, 32'h8000_0009);
        wb_read(6'd5, d);
        chk("depth_2", d, 32'd2);
        wb_write(6'd3, 32'd0);
        wb_read(6'd4, d);
        chk("curpri_restored", d, 32'd2);
        wb_read(6'd2, d);
        chk("reclaim_nested", d, 32'h8000_0009);
        wb_read(6'd5, d);
        chk("depth_2_again", d, 32'd2);
`else
        chk("no_preempt_irq", 32'(o_irq), 32'd0);
        wb_read(6'd2, d);
        chk("claim_blocked", d, 32'd0);
        wb_read(6'd5, d);
        chk("depth_stays_1", d, 32'd1);
        wb_write(6'd3, 32'd0);
        idle(1);
        chk("irq_after_eoi", 32'(o_irq), 32'd1);
        chk("id_after_eoi", 32'(o_irq_id), 32'd9);
        wb_read(6'd2, d);
        chk("claim_after_eoi", d, 32'h8000_0009);
`endif

        // Asynchronous reset during an outstanding read abandons it.
        wb.adr = {24'd0, 6'd5, 2'b00}; wb.sel = 4'hF; wb.we = 1'b0; wb.cyc = 1'b1; wb.stb = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", 32'(wb.ack), 32'd0);
        chk("rst_mid_irq", 32'(o_irq), 32'd0);
        chk("rst_mid_id", 32'(o_irq_id), 32'd0);
        chk("rst_mid_dat", wb.dat_r, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_no_ack", 32'(wb.ack), 32'd0);
        wb.cyc = 1'b0; wb.stb = 1'b0;
        ints = '0;
        idle(1);
        rst_n = 1'b1;
        wb_read(6'd0, d);
        chk("rst_enable", d, 32'd0);
        wb_read(6'd5, d);
        chk("rst_depth", d, 32'd0);
        wb_read(6'd25, d);
        chk("rst_prio9", d, 32'd0);

        // EOI on an empty stack and unmapped reads.
        wb_write(6'd3, 32'd0);
        wb_read(6'd5, d);
        chk("eoi_empty_depth", d, 32'd0);
        wb_read(6'd4, d);
        chk("eoi_empty_curpri", d, 32'd0);
        wb_read(6'd8, d);
        chk("unmapped_8", d, 32'd0);

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < NSRC; i++) wb_write(6'(16 + i), 32'($urandom_range(0, 15)));
        wb_write(6'd0, $urandom);
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) ints = NSRC'($urandom);
            case ($urandom_range(0, 7))
                0, 1:    wb_read(6'd2, d);
                2:       wb_write(6'd3, 32'd0);
                3:       wb_read(offs[$urandom_range(0, 11)], d);
                4:       wb_write(6'(16 + $urandom_range(0, NSRC - 1)), 32'($urandom_range(0, 15)));
                5:       wb_write(6'd0, $urandom);
                default: idle($urandom_range(1, 3));
            endcase
        end
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
